sseg_scan_drv: RTL and testbench

//   Downstream display stage of the BCD game: consumes the two challenge digits (Q1, Q2)
//   and the HEX/DEC mode flags from the next-state decoder and time-multiplexes them onto
//   the 4-digit common-anode seven-segment display. AN3 shows the mode letter, AN2 is blank,
//   AN1 shows Q1 and AN0 shows Q2. Inputs are frame-latched, so a state change never tears mid-scan.

---
 rtl/sseg_scan_drv.sv | 138 +++++++++++++
 tb/tb_sseg_scan_drv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_drv.sv
// sseg_scan_drv: 4-digit common-anode seven-segment scan driver.
// AN3 = mode letter, AN2 = blank, AN1 = Q1, AN0 = Q2. Inputs are latched once
// per frame so a display never tears mid-scan.
// Optional feature: define SSEG_BLINK_EN to add the BLINK input and a frame
// counter that blanks all anodes during frames 16-31 of every 32.
module sseg_scan_drv #(
  parameter int unsigned DIV_WIDTH = 17,
  parameter int unsigned BLANK_CYC = 64,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [3:0] Q1,
  input  logic [3:0] Q2,
  input  logic       HEX,
  input  logic       DEC,
`ifdef SSEG_BLINK_EN
  input  logic       BLINK,
`endif
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_HEX  = 2'b10,
    MODE_BAD  = 2'b11
  } mode_e;

  localparam logic [DIV_WIDTH-1:0] BLANK_LIM = DIV_WIDTH'(BLANK_CYC);

  logic [DIV_WIDTH-1:0] pre_q, pre_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           sq1_q, sq2_q;
  mode_e                smode_q;
  logic                 first_q;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic                 tick;
  logic                 frame_end;
  logic                 load;

`ifdef SSEG_BLINK_EN
  logic [4:0]           frame_q;
  logic                 sblink_q;
`endif

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Next-state for prescaler/index and next registered digit pattern.
  always_comb begin
    pre_d     = pre_q + DIV_WIDTH'(1);
    tick      = (pre_q == '1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    frame_end = tick && (idx_q == 2'd3);
    load      = first_q || frame_end;

    seg_d = 7'h7F;
    case (idx_q)
      2'd0: seg_d = hex_glyph(sq2_q);
      2'd1: seg_d = (BLANK_LZ && (sq1_q == 4'h0)) ? 7'h7F : hex_glyph(sq1_q);
      2'd2: seg_d = 7'h7F;
      default: begin
        case (smode_q)
          MODE_HEX: seg_d = 7'h09;
          MODE_DEC: seg_d = 7'h21;
          default:  seg_d = 7'h3F;
        endcase
      end
    endcase

    an_d = (pre_q < BLANK_LIM) ? 4'hF : ~(4'b0001 << idx_q);
`ifdef SSEG_BLINK_EN
    if (sblink_q && frame_q[4]) an_d = 4'hF;
`endif
  end

  // Scan counters, frame-latched shadow copy of the inputs, registered outputs.
  always_ff @(posedge CLK) begin
    if (R) begin
      pre_q   <= '0;
      idx_q   <= '0;
      sq1_q   <= '0;
      sq2_q   <= '0;
      smode_q <= MODE_NONE;
      first_q <= 1'b1;
      seg_q   <= '1;
      an_q    <= '1;
`ifdef SSEG_BLINK_EN
      frame_q  <= '0;
      sblink_q <= 1'b0;
`endif
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (load) begin
        sq1_q   <= Q1;
        sq2_q   <= Q2;
        smode_q <= mode_e'({HEX, DEC});
      end
`ifdef SSEG_BLINK_EN
      if (frame_end) frame_q <= frame_q + 5'd1;
      if (load) sblink_q <= BLINK;
`endif
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign DP  = 1'b1;

endmodule

// File: tb/tb_sseg_scan_drv.sv
// Directed bench for sseg_scan_drv with slot = 4 cycles, frame = 16 cycles.
// Two instances run in lockstep: leading-zero blanking on (a) and off (b).
module tb_sseg_scan_drv;

  logic       CLK;
  logic       R;
  logic [3:0] Q1, Q2;
  logic       HEX, DEC;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
`ifdef SSEG_BLINK_EN
  logic       blink;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // posedges since reset release

  sseg_scan_drv #(.DIV_WIDTH(2), .BLANK_CYC(1), .BLANK_LZ(1'b1)) u_a (
    .CLK(CLK), .R(R), .Q1(Q1), .Q2(Q2), .HEX(HEX), .DEC(DEC),
`ifdef SSEG_BLINK_EN
    .BLINK(blink),
`endif
    .SEG(seg_a), .DP(dp_a), .AN(an_a)
  );

  sseg_scan_drv #(.DIV_WIDTH(2), .BLANK_CYC(1), .BLANK_LZ(1'b0)) u_b (
    .CLK(CLK), .R(R), .Q1(Q1), .Q2(Q2), .HEX(HEX), .DEC(DEC),
`ifdef SSEG_BLINK_EN
    .BLINK(blink),
`endif
    .SEG(seg_b), .DP(dp_b), .AN(an_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [3:0] q1;
    logic [3:0] q2;
    logic       hex;
    logic       dec;
    logic [6:0] e0;    // AN0 glyph
    logic [6:0] e1;    // AN1 glyph, blanking on
    logic [6:0] e1n;   // AN1 glyph, blanking off
    logic [6:0] e3;    // AN3 mode glyph
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (j=%0d): got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // One clock: count the edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge CLK);
    if (R) k = 0;
    else   k++;
    @(negedge CLK);
  endtask

  task automatic apply(input vec_t v);
    Q1 = v.q1; Q2 = v.q2; HEX = v.hex; DEC = v.dec;
  endtask

  // Advance until the edge that latches the current inputs has just happened.
  task automatic wait_boundary();
    do step(); while ((k % 16) != 0);
  endtask

  function automatic logic [3:0] exp_an(input int slot, input int cyc);
    logic [3:0] a;
    if (cyc == 0) a = 4'hF;
    else begin
      case (slot)
        0: a = 4'hE;
        1: a = 4'hD;
        2: a = 4'hB;
        default: a = 4'h7;
      endcase
    end
    return a;
  endfunction

  // Check output cycles jstart..16 of one frame; optionally change Q2 before edge chg_at.
  task automatic check_frame(input vec_t v, input int jstart, input int chg_at, input logic [3:0] chg_val);
    logic [6:0] ea, eb;
    int slot, cyc;
    for (int j = jstart; j <= 16; j++) begin
      if (j == chg_at) Q2 = chg_val;
      step();
      slot = (j - 1) / 4;
      cyc  = (j - 1) % 4;
      case (slot)
        0: begin ea = v.e0; eb = v.e0;  end
        1: begin ea = v.e1; eb = v.e1n; end
        2: begin ea = 7'h7F; eb = 7'h7F; end
        default: begin ea = v.e3; eb = v.e3; end
      endcase
      chk("an_a",  j, 8'(an_a),  8'(exp_an(slot, cyc)));
      chk("seg_a", j, 8'(seg_a), 8'(ea));
      chk("an_b",  j, 8'(an_b),  8'(exp_an(slot, cyc)));
      chk("seg_b", j, 8'(seg_b), 8'(eb));
      if (cyc == 1) chk("dp", j, 8'({dp_b, dp_a}), 8'h03);
    end
  endtask

  initial begin
    vec_t vq21, vh11, vh00;

    //           q1    q2    hex   dec   e0     e1     e1n    e3
    vecs[0] = '{4'h2, 4'h9, 1'b0, 1'b1, 7'h10, 7'h24, 7'h24, 7'h21};
    vecs[1] = '{4'h0, 4'hD, 1'b1, 1'b0, 7'h21, 7'h7F, 7'h40, 7'h09};
    vecs[2] = '{4'hF, 4'hA, 1'b1, 1'b0, 7'h08, 7'h0E, 7'h0E, 7'h09};
    vecs[3] = '{4'h7, 4'h4, 1'b0, 1'b0, 7'h19, 7'h78, 7'h78, 7'h3F};
    vecs[4] = '{4'h1, 4'h0, 1'b1, 1'b1, 7'h40, 7'h79, 7'h79, 7'h3F};
    vecs[5] = '{4'hC, 4'hB, 1'b0, 1'b1, 7'h03, 7'h46, 7'h46, 7'h21};
    vecs[6] = '{4'h5, 4'h6, 1'b0, 1'b1, 7'h02, 7'h12, 7'h12, 7'h21};
    vecs[7] = '{4'hE, 4'h8, 1'b1, 1'b0, 7'h00, 7'h06, 7'h06, 7'h09};
    vecs[8] = '{4'h3, 4'h3, 1'b1, 1'b0, 7'h30, 7'h30, 7'h30, 7'h09};
    vq21    = '{4'h2, 4'h1, 1'b0, 1'b1, 7'h79, 7'h24, 7'h24, 7'h21};
    vh11    = '{4'h2, 4'h9, 1'b1, 1'b1, 7'h10, 7'h24, 7'h24, 7'h3F};
    vh00    = '{4'h2, 4'h9, 1'b0, 1'b0, 7'h10, 7'h24, 7'h24, 7'h3F};

    R = 1'b1; Q1 = '0; Q2 = '0; HEX = 1'b0; DEC = 1'b0;
`ifdef SSEG_BLINK_EN
    blink = 1'b0;
`endif
    @(negedge CLK);

    // Reset held 3 cycles, then release: AN0 goes low on the second edge.
    repeat (3) step();
    chk("rst_an",  0, 8'(an_a),  8'h0F);
    chk("rst_seg", 0, 8'(seg_a), 8'h7F);
    chk("rst_dp",  0, 8'(dp_a),  8'h01);
    chk("rst_anb", 0, 8'(an_b),  8'h0F);
    R = 1'b0;
    step();
    chk("rel1_an", 1, 8'(an_a), 8'h0F);
    step();
    chk("rel2_an",  2, 8'(an_a),  8'h0E);
    chk("rel2_seg", 2, 8'(seg_a), 8'h40);

    // Table-driven frames.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      wait_boundary();
      check_frame(vecs[i], 1, 0, 4'h0);
    end

    // Mid-frame input changes are not visible until the next frame.
    apply(vecs[0]);
    wait_boundary();
    check_frame(vecs[0], 1, 2, 4'h1);   // Q2 9->1 inside slot 0
    check_frame(vq21,    1, 6, 4'h9);   // Q2 1->9 while idx=1
    check_frame(vecs[0], 1, 0, 4'h0);

    // Illegal and empty mode both show '-'.
    apply(vh11);
    wait_boundary();
    check_frame(vh11, 1, 0, 4'h0);
    apply(vh00);
    check_frame(vh00, 1, 0, 4'h0);

    // At most one anode low, sampled over 1000 cycles.
    apply(vecs[2]);
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("onehot_a", i, 8'($countones(~an_a) <= 1), 8'h01);
      chk("onehot_b", i, 8'($countones(~an_b) <= 1), 8'h01);
    end

    // Reset mid-scan, then first frame loads inputs on the release cycle.
    wait_boundary();
    repeat (6) step();
    R = 1'b1;
    apply(vecs[1]);
    step();
    chk("mid_rst_an",  0, 8'(an_a),  8'h0F);
    chk("mid_rst_seg", 0, 8'(seg_a), 8'h7F);
    R = 1'b0;
    step();
    chk("post_rst_an",  1, 8'(an_a),  8'h0F);
    chk("post_rst_seg", 1, 8'(seg_a), 8'h40);
    check_frame(vecs[1], 2, 0, 4'h0);
    check_frame(vecs[1], 1, 0, 4'h0);

`ifdef SSEG_BLINK_EN
    // Blink: frames 16-31 of each 32 fully blanked, others scan normally.
    blink = 1'b1;
    wait_boundary();
    for (int i = 0; i < 1100; i++) begin
      int f, slot, cyc;
      step();
      f    = (k - 1) / 16;
      slot = ((k - 1) / 4) % 4;
      cyc  = (k - 1) % 4;
      if ((f % 32) >= 16) chk("blink_off", k, 8'(an_a), 8'h0F);
      else                chk("blink_on",  k, 8'(an_a), 8'(exp_an(slot, cyc)));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
